// File: rtl/pkg_memoria.sv
// Shared encodings for the MEM pipeline stage: access sizes, FSM states and
// the misalignment rule used to reject an access before it reaches the bus.
package pkg_memoria;

   localparam logic [1:0] TAM_BYTE      = 2'b00;
   localparam logic [1:0] TAM_MEDIA     = 2'b01;
   localparam logic [1:0] TAM_PALABRA   = 2'b10;
   localparam logic [1:0] TAM_RESERVADO = 2'b11;

   localparam logic REPOSO = 1'b0;
   localparam logic ACCESO = 1'b1;

   // Load and store together is treated as a malformed access, same as a bad size.
   function automatic logic desalineado(input logic [1:0] tam, input logic [1:0] dir,
                                        input logic leer, input logic escribir);
      return (tam == TAM_RESERVADO) ||
             ((tam == TAM_MEDIA) && dir[0]) ||
             ((tam == TAM_PALABRA) && (dir != 2'b00)) ||
             (leer && escribir);
   endfunction

endpackage

// File: rtl/extensor_carga.sv
// Picks the addressed byte/half lane out of a bus word and sign- or
// zero-extends it to 32 bits.
module extensor_carga
   import pkg_memoria::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  dir,
   input  logic [1:0]  tamano,
   input  logic        sin_signo,
   output logic [31:0] dato
);

   logic [7:0]  byte_sel;
   logic [15:0] media_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (dir)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      media_sel = dir[1] ? rdata[31:16] : rdata[15:0];

      case (tamano)
         TAM_BYTE:  dato = {{24{byte_sel[7] & ~sin_signo}}, byte_sel};
         TAM_MEDIA: dato = {{16{media_sel[15] & ~sin_signo}}, media_sel};
         default:   dato = rdata;
      endcase
   end

endmodule

// File: rtl/etapa_memoria.sv
// MEM pipeline stage: runs a req/ack data-memory transaction for loads and
// stores, extends load data and registers the result for the MEM/WB boundary.
module etapa_memoria
   import pkg_memoria::*;
#(
   parameter int unsigned LIMITE_ESPERA = 16
) (
   input  logic        clk,
   input  logic        reinicio,
   input  logic [31:0] pc_entrada,
   input  logic [31:0] resultado_alu_entrada,
   input  logic [31:0] dato_mem_entrada,
   input  logic [4:0]  registro_destino_entrada,
   input  logic        leer,
   input  logic        escribir,
   input  logic [1:0]  tamano,
   input  logic        sin_signo,
   input  logic        escribe_reg_entrada,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_dir,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        detener,
   output logic [31:0] pc_salida,
   output logic [31:0] dato_wb_salida,
   output logic [4:0]  registro_destino_salida,
   output logic        escribe_reg_salida,
   output logic        error_alineacion,
   output logic        error_bus
);

   localparam int unsigned CW = (LIMITE_ESPERA > 1) ? $clog2(LIMITE_ESPERA) : 1;
   localparam logic [CW-1:0] CUENTA_MAX = CW'(LIMITE_ESPERA - 1);

   logic          estado_q;
   logic [CW-1:0] contador_q;

   // Copy of the in-flight instruction, so the result does not depend on upstream.
   logic [31:0] dir_q;
   logic [31:0] pc_t_q;
   logic [4:0]  rd_t_q;
   logic [1:0]  tamano_q;
   logic        sin_signo_q;
   logic        leer_q;
   logic        esc_reg_t_q;

   logic        acceso;
   logic        mal;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] carga;

   assign acceso = leer | escribir;
   assign mal    = desalineado(tamano, resultado_alu_entrada[1:0], leer, escribir);

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = dato_mem_entrada;
      case (tamano)
         TAM_BYTE: begin
            be_calc    = 4'b0001 << resultado_alu_entrada[1:0];
            wdata_calc = {4{dato_mem_entrada[7:0]}};
         end
         TAM_MEDIA: begin
            be_calc    = 4'b0011 << resultado_alu_entrada[1:0];
            wdata_calc = {2{dato_mem_entrada[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = dato_mem_entrada;
         end
      endcase
   end

   always_comb begin
      if (estado_q == ACCESO) detener = !mem_ack && (contador_q != CUENTA_MAX);
      else                    detener = acceso && !mal;
   end

   extensor_carga u_extensor (
      .rdata     (mem_rdata),
      .dir       (dir_q[1:0]),
      .tamano    (tamano_q),
      .sin_signo (sin_signo_q),
      .dato      (carga)
   );

   always_ff @(posedge clk) begin
      if (reinicio) begin
         estado_q                <= REPOSO;
         contador_q              <= '0;
         dir_q                   <= '0;
         pc_t_q                  <= '0;
         rd_t_q                  <= '0;
         tamano_q                <= '0;
         sin_signo_q             <= 1'b0;
         leer_q                  <= 1'b0;
         esc_reg_t_q             <= 1'b0;
         mem_req                 <= 1'b0;
         mem_we                  <= 1'b0;
         mem_dir                 <= '0;
         mem_be                  <= '0;
         mem_wdata               <= '0;
         pc_salida               <= '0;
         dato_wb_salida          <= '0;
         registro_destino_salida <= '0;
         escribe_reg_salida      <= 1'b0;
         error_alineacion        <= 1'b0;
         error_bus               <= 1'b0;
      end else begin
         error_alineacion   <= 1'b0;
         error_bus          <= 1'b0;
         escribe_reg_salida <= 1'b0;
         if (estado_q == REPOSO) begin
            if (!acceso) begin
               pc_salida               <= pc_entrada;
               dato_wb_salida          <= resultado_alu_entrada;
               registro_destino_salida <= registro_destino_entrada;
               escribe_reg_salida      <= escribe_reg_entrada &&
                                          (registro_destino_entrada != 5'd0);
            end else if (mal) begin
               error_alineacion <= 1'b1;
            end else begin
               estado_q    <= ACCESO;
               contador_q  <= '0;
               mem_req     <= 1'b1;
               mem_we      <= escribir;
               mem_dir     <= {resultado_alu_entrada[31:2], 2'b00};
               mem_be      <= be_calc;
               mem_wdata   <= wdata_calc;
               dir_q       <= resultado_alu_entrada;
               pc_t_q      <= pc_entrada;
               rd_t_q      <= registro_destino_entrada;
               tamano_q    <= tamano;
               sin_signo_q <= sin_signo;
               leer_q      <= leer;
               esc_reg_t_q <= escribe_reg_entrada;
            end
         end else begin
            // An ack in the final wait cycle still completes the access.
            if (mem_ack) begin
               estado_q                <= REPOSO;
               contador_q              <= '0;
               mem_req                 <= 1'b0;
               mem_we                  <= 1'b0;
               pc_salida               <= pc_t_q;
               registro_destino_salida <= rd_t_q;
               dato_wb_salida          <= leer_q ? carga : dir_q;
               escribe_reg_salida      <= leer_q && esc_reg_t_q && (rd_t_q != 5'd0);
            end else if (contador_q == CUENTA_MAX) begin
               estado_q   <= REPOSO;
               contador_q <= '0;
               mem_req    <= 1'b0;
               mem_we     <= 1'b0;
               error_bus  <= 1'b1;
            end else begin
               contador_q <= contador_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_etapa_memoria.sv
// Bench for etapa_memoria: directed scenarios followed by random operations,
// checked against an arithmetic model of the stage.
module tb_etapa_memoria;

   localparam int unsigned LIM = 4;

   logic        clk = 1'b0;
   logic        reinicio;
   logic [31:0] pc_entrada;
   logic [31:0] resultado_alu_entrada;
   logic [31:0] dato_mem_entrada;
   logic [4:0]  registro_destino_entrada;
   logic        leer;
   logic        escribir;
   logic [1:0]  tamano;
   logic        sin_signo;
   logic        escribe_reg_entrada;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_dir;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        detener;
   logic [31:0] pc_salida;
   logic [31:0] dato_wb_salida;
   logic [4:0]  registro_destino_salida;
   logic        escribe_reg_salida;
   logic        error_alineacion;
   logic        error_bus;

   int n_checks = 0;
   int n_fail   = 0;

   etapa_memoria #(.LIMITE_ESPERA(LIM)) dut (
      .clk                      (clk),
      .reinicio                 (reinicio),
      .pc_entrada               (pc_entrada),
      .resultado_alu_entrada    (resultado_alu_entrada),
      .dato_mem_entrada         (dato_mem_entrada),
      .registro_destino_entrada (registro_destino_entrada),
      .leer                     (leer),
      .escribir                 (escribir),
      .tamano                   (tamano),
      .sin_signo                (sin_signo),
      .escribe_reg_entrada      (escribe_reg_entrada),
      .mem_req                  (mem_req),
      .mem_we                   (mem_we),
      .mem_dir                  (mem_dir),
      .mem_be                   (mem_be),
      .mem_wdata                (mem_wdata),
      .mem_ack                  (mem_ack),
      .mem_rdata                (mem_rdata),
      .detener                  (detener),
      .pc_salida                (pc_salida),
      .dato_wb_salida           (dato_wb_salida),
      .registro_destino_salida  (registro_destino_salida),
      .escribe_reg_salida       (escribe_reg_salida),
      .error_alineacion         (error_alineacion),
      .error_bus                (error_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, mem_req, 0);
      check({tag, "_we"}, mem_we, 0);
      check({tag, "_dir"}, mem_dir, 0);
      check({tag, "_be"}, mem_be, 0);
      check({tag, "_wdata"}, mem_wdata, 0);
      check({tag, "_pc"}, pc_salida, 0);
      check({tag, "_wb"}, dato_wb_salida, 0);
      check({tag, "_rd"}, registro_destino_salida, 0);
      check({tag, "_esc"}, escribe_reg_salida, 0);
      check({tag, "_erral"}, error_alineacion, 0);
      check({tag, "_errbus"}, error_bus, 0);
   endtask

   // One instruction through MEM; ack_delay = wait cycles before ack, or >= LIM for none.
   task automatic do_op(input logic [31:0] a_pc, input logic [31:0] a_alu,
                        input logic [31:0] a_d, input logic [4:0] a_rd,
                        input logic a_leer, input logic a_escr, input logic [1:0] a_tam,
                        input logic a_ss, input logic a_we, input int ack_delay,
                        input logic [31:0] a_rdata);
      logic        mal;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] ld;
      int          sh;
      bit          done;
      pc_entrada               = a_pc;
      resultado_alu_entrada    = a_alu;
      dato_mem_entrada         = a_d;
      registro_destino_entrada = a_rd;
      leer                     = a_leer;
      escribir                 = a_escr;
      tamano                   = a_tam;
      sin_signo                = a_ss;
      escribe_reg_entrada      = a_we;
      mem_ack                  = 1'b0;
      mem_rdata                = $urandom;
      mal = (a_tam == 2'd3) || (a_tam == 2'd1 && a_alu[0]) ||
            (a_tam == 2'd2 && a_alu[1:0] != 2'd0) || (a_leer && a_escr);
      #1;
      if (!a_leer && !a_escr) begin
         check("alu_det", detener, 0);
         tick();
         check("alu_pc", pc_salida, a_pc);
         check("alu_wb", dato_wb_salida, a_alu);
         check("alu_rd", registro_destino_salida, a_rd);
         check("alu_esc", escribe_reg_salida, a_we && (a_rd != 0));
         check("alu_erral", error_alineacion, 0);
         check("alu_errbus", error_bus, 0);
         check("alu_req", mem_req, 0);
      end else if (mal) begin
         check("mal_det", detener, 0);
         tick();
         check("mal_erral", error_alineacion, 1);
         check("mal_esc", escribe_reg_salida, 0);
         check("mal_req", mem_req, 0);
         check("mal_errbus", error_bus, 0);
      end else begin
         check("acc_det0", detener, 1);
         tick();
         sh = 8 * int'(a_alu[1:0]);
         if (a_tam == 2'd0) begin
            be = 4'(1 << a_alu[1:0]);
            wd = a_d[7:0] * 32'h0101_0101;
            ld = (a_rdata >> sh) & 32'hFF;
            if (!a_ss && ld >= 32'h80) ld = ld | 32'hFFFF_FF00;
         end else if (a_tam == 2'd1) begin
            be = 4'(3 << a_alu[1:0]);
            wd = a_d[15:0] * 32'h0001_0001;
            ld = (a_rdata >> (a_alu[1] ? 16 : 0)) & 32'hFFFF;
            if (!a_ss && ld >= 32'h8000) ld = ld | 32'hFFFF_0000;
         end else begin
            be = 4'hF;
            wd = a_d;
            ld = a_rdata;
         end
         check("acc_req", mem_req, 1);
         check("acc_we", mem_we, a_escr);
         check("acc_dir", mem_dir, a_alu & 32'hFFFF_FFFC);
         check("acc_be", mem_be, be);
         check("acc_wdata", mem_wdata, wd);
         done = 0;
         for (int k = 0; k < int'(LIM) && !done; k++) begin
            mem_ack   = (k == ack_delay);
            mem_rdata = mem_ack ? a_rdata : $urandom;
            #1;
            check("acc_det", detener, !mem_ack && (k != int'(LIM) - 1));
            tick();
            if (k == ack_delay) begin
               mem_ack = 1'b0;
               done    = 1;
               check("ack_req", mem_req, 0);
               check("ack_we", mem_we, 0);
               check("ack_esc", escribe_reg_salida, a_leer && a_we && (a_rd != 0));
               check("ack_rd", registro_destino_salida, a_rd);
               check("ack_pc", pc_salida, a_pc);
               check("ack_errbus", error_bus, 0);
               if (a_leer) check("ack_wb", dato_wb_salida, ld);
            end else if (k == int'(LIM) - 1) begin
               check("to_errbus", error_bus, 1);
               check("to_req", mem_req, 0);
               check("to_esc", escribe_reg_salida, 0);
            end else begin
               check("wait_req", mem_req, 1);
               check("wait_esc", escribe_reg_salida, 0);
            end
         end
      end
   endtask

   initial begin
      logic [31:0] alu;
      logic [1:0]  tam;
      int          tipo;
      reinicio = 1'b1;
      pc_entrada = '0; resultado_alu_entrada = '0; dato_mem_entrada = '0;
      registro_destino_entrada = '0; leer = 0; escribir = 0; tamano = '0;
      sin_signo = 0; escribe_reg_entrada = 0; mem_ack = 0; mem_rdata = '0;
      tick();
      tick();
      check_all_zero("rst");
      reinicio = 1'b0;

      do_op(32'h40, 32'h0000_1234, 0, 5'd5, 0, 0, 2'd2, 0, 1, -1, 0);
      do_op(32'h44, 32'h0000_0103, 0, 5'd6, 1, 0, 2'd0, 0, 1, 2, 32'h80FF_FF7F);
      check("lb_value", dato_wb_salida, 32'hFFFF_FF80);
      do_op(32'h48, 32'h0000_0202, 32'h0000_ABCD, 5'd7, 0, 1, 2'd1, 0, 1, 0, 0);
      do_op(32'h4C, 32'h0000_0101, 0, 5'd8, 1, 0, 2'd2, 0, 1, 0, 0);
      do_op(32'h50, 32'h0000_0300, 0, 5'd9, 1, 0, 2'd2, 0, 1, -1, 0);

      // Late ack after timeout must not start or complete anything.
      leer = 0; escribir = 0; resultado_alu_entrada = 32'h5555; registro_destino_entrada = 0;
      mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      check("late_req", mem_req, 0);
      check("late_wb", dato_wb_salida, 32'h5555);
      check("late_esc", escribe_reg_salida, 0);
      check("late_errbus", error_bus, 0);
      mem_ack = 0;

      // Reset while an access is in flight.
      resultado_alu_entrada = 32'h400; leer = 1; tamano = 2'd2;
      registro_destino_entrada = 5'd3; escribe_reg_entrada = 1;
      tick();
      check("mid_req", mem_req, 1);
      reinicio = 1;
      tick();
      check_all_zero("midrst");
      reinicio = 0; leer = 0; escribe_reg_entrada = 0; resultado_alu_entrada = 0;
      registro_destino_entrada = 0; pc_entrada = 0;
      mem_ack = 1; mem_rdata = 32'h1234_5678;
      #1;
      check("postrst_det", detener, 0);
      tick();
      check("postrst_esc", escribe_reg_salida, 0);
      check("postrst_req", mem_req, 0);
      check("postrst_wb", dato_wb_salida, 0);
      mem_ack = 0;

      for (int i = 0; i < 60; i++) begin
         tipo = $urandom_range(0, 3);
         alu  = $urandom;
         tam  = 2'($urandom_range(0, 2));
         if (tipo == 1 || tipo == 2) begin
            if (tam == 2'd1) alu[0] = 1'b0;
            if (tam == 2'd2) alu[1:0] = 2'b00;
         end
         if (tipo == 3) tam = 2'($urandom_range(0, 3));
         do_op($urandom, alu, $urandom, 5'($urandom),
               (tipo == 1) || (tipo == 3 && $urandom_range(0, 1) == 1),
               (tipo == 2) || (tipo == 3 && $urandom_range(0, 1) == 1),
               tam, 1'($urandom), 1'($urandom), $urandom_range(0, 5), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
